shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of bits serialized per word; legal range 2..15.
REQ-002 SHALL have port C, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nR, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port PD, input, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have port PV, input, 1 bit: PD valid.
REQ-006 SHALL have port PR, output, 1 bit: ready to accept PD.
REQ-007 SHALL have port HOLD, input, 1 bit: pause shifting.
REQ-008 SHALL have port SO, output, 1 bit: serial bit driving the D input of the downstream shift-register chain.
REQ-009 SHALL have port SE, output, 1 bit: shift enable, gating the clock of the downstream chain.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle end-of-word pulse.
REQ-011 SHALL have port CNT, output, 4 bits: number of bits already shifted in the current word.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and FIN, all registered.
REQ-013 IDLE: PR=1, SE=0, SO=0, DONE=0, CNT=0.
REQ-014 IDLE, at a rising edge with PV=1: PD SHALL be captured into an internal buffer, CNT cleared, and the state SHALL become SHIFT.
REQ-015 IDLE with PV=0: SHALL remain in IDLE; PD is ignored.
REQ-016 SHIFT: PR=0, DONE=0, SO=buf[0] (LSB first), SE=!HOLD.
REQ-017 SHIFT, at an edge with HOLD=0: buf SHALL shift right by one (zero fill) and CNT SHALL increment.
REQ-018 SHIFT, at an edge with HOLD=1: buf, CNT, SO and the state SHALL be frozen.
REQ-019 SHIFT, at an edge with HOLD=0 and CNT==WIDTH-1: the state SHALL become FIN and CNT SHALL become WIDTH.
REQ-020 FIN: DONE=1, SE=0, PR=0, SO=0, CNT=WIDTH; the next edge SHALL return to IDLE with CNT=0.
REQ-021 Latency: if PV is accepted at edge k, SO SHALL carry PD[0..WIDTH-1] during cycles k+1..k+WIDTH (HOLD=0).
REQ-022 Latency (continued): DONE SHALL be high during cycle k+WIDTH+1 only, and PR SHALL rise in cycle k+WIDTH+2.
REQ-023 Each HOLD-high cycle in SHIFT SHALL extend every subsequent timing by exactly one cycle.
REQ-024 HOLD SHALL have no effect in IDLE or FIN.
REQ-025 PV or PD changes during SHIFT or FIN SHALL be ignored and not queued; no back-to-back acceptance in FIN.
REQ-026 SE, PR and DONE SHALL be glitch-free, decoded directly from registered state and HOLD only.
REQ-027 CNT SHALL never exceed WIDTH and SHALL not wrap.

Reset
REQ-028 When nR=0 at a rising edge: state SHALL become IDLE, buf=0 and CNT=0, taking priority over PV and HOLD.
REQ-029 Outputs during reset: the cycle after a reset edge SHALL show PR=1, SE=0, SO=0, DONE=0, CNT=0.
REQ-030 Reset during SHIFT SHALL abort the word with no DONE pulse; the partial word is discarded.
REQ-031 After release of nR: PV=1 at the first edge with nR=1 SHALL be accepted.

Verification
REQ-032 WIDTH=8, PD=8'hA5, PV=1 one cycle, HOLD=0 -> SO=1,0,1,0,0,1,0,1 over 8 cycles, SE=1 throughout, DONE pulse in cycle 9, PR=1 in cycle 10.
REQ-033 WIDTH=8, PD=8'h0F, HOLD=1 for 3 cycles after bit 2 -> SE=0 and SO/CNT=2 frozen for those 3 cycles, DONE delayed to cycle 12.
REQ-034 nR=0 during SHIFT at CNT=4 -> next cycle IDLE, CNT=0, SE=0, no DONE.
REQ-035 PV=1 with PD=8'hFF while in SHIFT of 8'h00 -> SO stays 0 for all 8 bits, word 8'hFF is not transmitted afterwards.
REQ-036 WIDTH=2, PD=2'b10, PV held high continuously -> SO=0,1, DONE, one IDLE cycle with PR=1, then re-acceptance; period 4 cycles per word.
REQ-037 nR=0 with PV=1 and HOLD=1 simultaneously -> IDLE, PR=1, CNT=0, nothing captured.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and serial-output bundle for shift_seq_ctrl.
// The producer side (master) supplies the parallel word, its valid flag and
// the pause request; the serializer (slave) returns ready, the serial bit,
// the downstream shift enable, the end-of-word pulse and the bit count.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] PD;
  logic             PV;
  logic             PR;
  logic             HOLD;
  logic             SO;
  logic             SE;
  logic             DONE;
  logic [3:0]       CNT;

  modport master (
    output PD, PV, HOLD,
    input  PR, SO, SE, DONE, CNT
  );

  modport slave (
    input  PD, PV, HOLD,
    output PR, SO, SE, DONE, CNT
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer feeding an external shift-register chain.
// A word is captured from PD when PV is seen in IDLE, then shifted out LSB
// first on SO, one bit per cycle, while SE gates the downstream chain clock.
// HOLD pauses shifting in place. A one-cycle DONE marks the end of the word,
// after which the block returns to IDLE and can accept the next word.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready (PR=1), waiting for PV; outputs quiet, CNT=0
//   SHIFT | presenting buf[0] on SO; advances on every cycle with HOLD=0
//   FIN   | word complete: DONE=1 for one cycle, CNT=WIDTH
//
// PR, DONE and the SHIFT qualifier are flops set alongside the state, so the
// only combinational term on SE is the HOLD gate and SO is a two-flop AND;
// none of them can glitch from next-state decode.
module shift_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             C,
  input logic             nR,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);
  localparam logic [3:0] CNT_FULL = 4'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] buf_q;
  logic [3:0]       cnt_q;
  logic             pr_q;
  logic             done_q;
  logic             shift_q;

  // Sequencer: state, shift buffer, bit counter and registered output flags.
  always_ff @(posedge C) begin
    if (!nR) begin
      state   <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      pr_q    <= 1'b1;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.PV) begin
            state   <= SHIFT;
            buf_q   <= bus.PD;
            cnt_q   <= '0;
            pr_q    <= 1'b0;
            shift_q <= 1'b1;
          end
        end
        SHIFT: begin
          // HOLD freezes everything; PV/PD are not looked at here, so
          // nothing offered mid-word is queued.
          if (!bus.HOLD) begin
            buf_q <= {1'b0, buf_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
              state   <= FIN;
              cnt_q   <= CNT_FULL;
              shift_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        FIN: begin
          // Unconditional single cycle; no acceptance here even with PV=1.
          state  <= IDLE;
          cnt_q  <= '0;
          done_q <= 1'b0;
          pr_q   <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          buf_q   <= '0;
          cnt_q   <= '0;
          pr_q    <= 1'b1;
          done_q  <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  // Output decode from registered flags; SE is additionally gated by HOLD.
  always_comb begin
    bus.PR   = pr_q;
    bus.DONE = done_q;
    bus.SO   = shift_q & buf_q[0];
    bus.SE   = shift_q & ~bus.HOLD;
    bus.CNT  = cnt_q;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: one WIDTH=8 instance and one WIDTH=2
// instance on a shared clock and reset.
module tb_shift_seq_ctrl;

  logic C;
  logic nR;
  int   n_cmp;
  int   n_err;

  shift_seq_ctrl_if #(.WIDTH(8)) ia ();
  shift_seq_ctrl_if #(.WIDTH(2)) ib ();

  shift_seq_ctrl #(.WIDTH(8)) dut_a (.C(C), .nR(nR), .bus(ia.slave));
  shift_seq_ctrl #(.WIDTH(2)) dut_b (.C(C), .nR(nR), .bus(ib.slave));

  // Free-running clock, period 10.
  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic tick();
    @(posedge C);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic pr, input logic se,
                       input logic so, input logic done, input logic [3:0] cnt);
    chk({tag, ".PR"},   8'(ia.PR),   8'(pr));
    chk({tag, ".SE"},   8'(ia.SE),   8'(se));
    chk({tag, ".SO"},   8'(ia.SO),   8'(so));
    chk({tag, ".DONE"}, 8'(ia.DONE), 8'(done));
    chk({tag, ".CNT"},  8'(ia.CNT),  8'(cnt));
  endtask

  task automatic chk_b(input string tag, input logic pr, input logic se,
                       input logic so, input logic done, input logic [3:0] cnt);
    chk({tag, ".PR"},   8'(ib.PR),   8'(pr));
    chk({tag, ".SE"},   8'(ib.SE),   8'(se));
    chk({tag, ".SO"},   8'(ib.SO),   8'(so));
    chk({tag, ".DONE"}, 8'(ib.DONE), 8'(done));
    chk({tag, ".CNT"},  8'(ib.CNT),  8'(cnt));
  endtask

  // Hand-computed LSB-first bit streams.
  logic so_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic so_0f [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic       hold_now;
    logic [3:0] cnt_exp;

    n_cmp = 0;
    n_err = 0;
    nR = 1'b0;
    ia.PD = 8'h00; ia.PV = 1'b0; ia.HOLD = 1'b0;
    ib.PD = 2'b00; ib.PV = 1'b0; ib.HOLD = 1'b0;

    // Reset state on both instances.
    tick();
    tick();
    chk_a("rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    chk_b("rst_b", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Word 8'hA5 offered at the first edge with nR released.
    nR = 1'b1;
    ia.PD = 8'hA5; ia.PV = 1'b1;
    tick();
    ia.PV = 1'b0; ia.PD = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_a("a5_bit", 1'b0, 1'b1, so_a5[i], 1'b0, 4'(i));
      tick();
    end
    chk_a("a5_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    tick();
    chk_a("a5_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Word 8'h0F with HOLD high for the three cycles that show CNT=2.
    ia.PD = 8'h0F; ia.PV = 1'b1;
    tick();
    ia.PV = 1'b0; ia.PD = 8'h00;
    for (int c = 1; c <= 11; c++) begin
      hold_now = (c >= 3 && c <= 5);
      ia.HOLD = hold_now;
      #1;
      if (c <= 3)      cnt_exp = 4'(c - 1);
      else if (c <= 6) cnt_exp = 4'd2;
      else             cnt_exp = 4'(c - 4);
      chk_a("0f_bit", 1'b0, ~hold_now, so_0f[cnt_exp[2:0]], 1'b0, cnt_exp);
      tick();
    end
    // HOLD during FIN must not stretch it.
    ia.HOLD = 1'b1;
    #1;
    chk_a("0f_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    tick();
    chk_a("0f_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    ia.HOLD = 1'b0;

    // Reset in SHIFT at CNT=4 aborts with no DONE.
    ia.PD = 8'h3C; ia.PV = 1'b1;
    tick();
    ia.PV = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_a("abort_pre", 1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    nR = 1'b0;
    tick();
    chk_a("abort_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    nR = 1'b1;
    tick();
    chk_a("abort_after", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // PV/PD=8'hFF offered throughout SHIFT and FIN of 8'h00 is ignored.
    ia.PD = 8'h00; ia.PV = 1'b1;
    tick();
    ia.PD = 8'hFF; ia.PV = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_a("ign_bit", 1'b0, 1'b1, 1'b0, 1'b0, 4'(i));
      tick();
    end
    chk_a("ign_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    ia.PV = 1'b0;
    tick();
    chk_a("ign_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_a("ign_noq", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // WIDTH=2, PD=2'b10, PV held high: 4-cycle period per word.
    ib.PD = 2'b10; ib.PV = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      chk_b("w2_b0",   1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tick();
      chk_b("w2_b1",   1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
      tick();
      chk_b("w2_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
      tick();
      chk_b("w2_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
    end
    chk_b("w2_reacc", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    ib.PV = 1'b0;
    tick();
    tick();
    tick();
    chk_b("w2_end", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset wins over PV and HOLD; nothing is captured.
    nR = 1'b0;
    ia.PD = 8'hAA; ia.PV = 1'b1; ia.HOLD = 1'b1;
    tick();
    chk_a("rst_pri", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    nR = 1'b1;
    ia.PV = 1'b0; ia.HOLD = 1'b0;
    tick();
    chk_a("rst_nocap", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // HOLD is ignored in IDLE: PV with HOLD high is still accepted.
    ia.PD = 8'h01; ia.PV = 1'b1; ia.HOLD = 1'b1;
    tick();
    ia.PV = 1'b0;
    #1;
    chk_a("idle_hold", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    ia.HOLD = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
